// File: rtl/seg_595_receiver.sv
// Receiver for the 74HC595 display link: oversamples ds/shcp/stcp/oe,
// rebuilds latched frames and mirrors the 6-digit segment table.
module seg_595_receiver #(
  parameter int FRAME_BITS  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic [7:0]  seg_q,
  output logic [5:0]  sel_q,
  output logic [47:0] digits,
  output logic        frame_vld,
  output logic        frame_err
);

  localparam int NS = SYNC_STAGES;
  localparam logic [4:0] FB = 5'(FRAME_BITS);

  logic [NS-1:0] ds_sync_q, ds_sync_d;
  logic [NS-1:0] shcp_sync_q, shcp_sync_d;
  logic [NS-1:0] stcp_sync_q, stcp_sync_d;
  logic [NS-1:0] oe_sync_q, oe_sync_d;
  logic          shcp_hist_q, shcp_hist_d;
  logic          stcp_hist_q, stcp_hist_d;

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [FRAME_BITS-1:0] lat_q, lat_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic                  lat_evt_q, lat_evt_d;
  logic                  lat_ok_q, lat_ok_d;
  logic                  upd_q, upd_d;
  logic                  frame_vld_q, frame_vld_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            seg_r_q, seg_r_d;
  logic [5:0]            sel_r_q, sel_r_d;
  logic [47:0]           digits_q, digits_d;

  logic       ds_s, shcp_s, stcp_s, oe_s;
  logic       shcp_rise, stcp_rise;
  logic [4:0] cnt_inc, cnt_used;
  logic [5:0] lat_sel;
  logic       sel_onehot;

  always_comb begin
    ds_sync_d   = {ds_sync_q[NS-2:0], ds};
    shcp_sync_d = {shcp_sync_q[NS-2:0], shcp};
    stcp_sync_d = {stcp_sync_q[NS-2:0], stcp};
    oe_sync_d   = {oe_sync_q[NS-2:0], oe};
    ds_s        = ds_sync_q[NS-1];
    shcp_s      = shcp_sync_q[NS-1];
    stcp_s      = stcp_sync_q[NS-1];
    oe_s        = oe_sync_q[NS-1];
    shcp_hist_d = shcp_s;
    stcp_hist_d = stcp_s;
    shcp_rise   = shcp_s & ~shcp_hist_q;
    stcp_rise   = stcp_s & ~stcp_hist_q;
  end

  // Shift happens before latch so a tied shcp/stcp edge includes the new bit
  always_comb begin
    cnt_inc   = (bit_cnt_q == 5'd31) ? 5'd31 : bit_cnt_q + 5'd1;
    cnt_used  = shcp_rise ? cnt_inc : bit_cnt_q;
    sr_d      = shcp_rise ? {sr_q[FRAME_BITS-2:0], ds_s} : sr_q;
    bit_cnt_d = stcp_rise ? 5'd0 : cnt_used;
    lat_d     = stcp_rise ? sr_d : lat_q;
    lat_evt_d = stcp_rise;
    lat_ok_d  = stcp_rise && (cnt_used == FB);
  end

  always_comb begin
    lat_sel     = lat_q[13:8];
    sel_onehot  = (lat_sel != 6'd0) &&
                  ((lat_sel & (lat_sel - 6'd1)) == 6'd0);
    frame_vld_d = lat_evt_q & lat_ok_q;
    frame_err_d = lat_evt_q & ~lat_ok_q;
    seg_r_d     = oe_s ? 8'h00 : lat_q[7:0];
    sel_r_d     = oe_s ? 6'h00 : lat_sel;
    upd_d       = lat_evt_q & sel_onehot;
    digits_d    = digits_q;
    if (upd_q) begin
      for (int i = 0; i < 6; i++) begin
        if (lat_sel[i]) digits_d[8*i +: 8] = lat_q[7:0];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ds_sync_q   <= '0;
      shcp_sync_q <= '0;
      stcp_sync_q <= '0;
      oe_sync_q   <= '1;
      shcp_hist_q <= 1'b0;
      stcp_hist_q <= 1'b0;
      sr_q        <= '0;
      lat_q       <= '0;
      bit_cnt_q   <= 5'd0;
      lat_evt_q   <= 1'b0;
      lat_ok_q    <= 1'b0;
      upd_q       <= 1'b0;
      frame_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      seg_r_q     <= 8'h00;
      sel_r_q     <= 6'h00;
      digits_q    <= '0;
    end else begin
      ds_sync_q   <= ds_sync_d;
      shcp_sync_q <= shcp_sync_d;
      stcp_sync_q <= stcp_sync_d;
      oe_sync_q   <= oe_sync_d;
      shcp_hist_q <= shcp_hist_d;
      stcp_hist_q <= stcp_hist_d;
      sr_q        <= sr_d;
      lat_q       <= lat_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_evt_q   <= lat_evt_d;
      lat_ok_q    <= lat_ok_d;
      upd_q       <= upd_d;
      frame_vld_q <= frame_vld_d;
      frame_err_q <= frame_err_d;
      seg_r_q     <= seg_r_d;
      sel_r_q     <= sel_r_d;
      digits_q    <= digits_d;
    end
  end

  assign seg_q     = seg_r_q;
  assign sel_q     = sel_r_q;
  assign digits    = digits_q;
  assign frame_vld = frame_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_seg_595_receiver.sv
// Scoreboard bench for seg_595_receiver: directed frames push expected
// flags/fields/digits; a monitor pops and compares on each flag pulse.
module tb_seg_595_receiver;

  logic        sys_clk = 1'b0;
  logic        sys_rst, ds, shcp, stcp, oe;
  logic [7:0]  seg_q;
  logic [5:0]  sel_q;
  logic [47:0] digits;
  logic        frame_vld, frame_err;

  seg_595_receiver #(.FRAME_BITS(14), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp),
    .stcp(stcp), .oe(oe), .seg_q(seg_q), .sel_q(sel_q),
    .digits(digits), .frame_vld(frame_vld), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        vld;
    logic        err;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic [47:0] dig;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_dig = '0;

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(posedge sys_clk);
  endtask

  task automatic shift_bit(logic b);
    ds = b;
    clks(2);
    shcp = 1'b1;
    clks(4);
    shcp = 1'b0;
    clks(4);
  endtask

  // shifts the top n bits of f, MSB first
  task automatic shift_bits(logic [13:0] f, int n);
    for (int i = 13; i > 13 - n; i--) shift_bit(f[i]);
  endtask

  task automatic latch();
    stcp = 1'b1;
    clks(4);
    stcp = 1'b0;
    clks(6);
  endtask

  task automatic expect_frame(logic vld, logic err, logic [5:0] sel,
                              logic [7:0] seg, logic masked);
    exp_t x;
    if ($countones(sel) == 1) begin
      for (int i = 0; i < 6; i++)
        if (sel[i]) exp_dig[8*i +: 8] = seg;
    end
    x.vld = vld;
    x.err = err;
    x.seg = masked ? 8'h00 : seg;
    x.sel = masked ? 6'h00 : sel;
    x.dig = exp_dig;
    q.push_back(x);
  endtask

  task automatic send(logic [5:0] sel, logic [7:0] seg, logic masked);
    expect_frame(1'b1, 1'b0, sel, seg, masked);
    shift_bits({sel, seg}, 14);
    latch();
  endtask

  always begin
    @(negedge sys_clk);
    if (!sys_rst && (frame_vld || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flag: got vld=%b err=%b, expected none",
                 frame_vld, frame_err);
      end else begin
        e = q.pop_front();
        chk("frame_vld", 48'(frame_vld), 48'(e.vld));
        chk("frame_err", 48'(frame_err), 48'(e.err));
        chk("seg_q", 48'(seg_q), 48'(e.seg));
        chk("sel_q", 48'(sel_q), 48'(e.sel));
        @(negedge sys_clk);
        chk("digits", digits, e.dig);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [13:0] f;
    sys_rst = 1'b1;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b0;
    clks(3);
    sys_rst = 1'b0;
    clks(4);
    #1;
    chk("rst seg_q", 48'(seg_q), 48'h0);
    chk("rst sel_q", 48'(sel_q), 48'h0);
    chk("rst digits", digits, 48'h0);
    chk("rst frame_vld", 48'(frame_vld), 48'h0);
    chk("rst frame_err", 48'(frame_err), 48'h0);

    send(6'b000001, 8'hC0, 1'b0);

    send(6'h01, 8'hF9, 1'b0);
    send(6'h02, 8'hA4, 1'b0);
    send(6'h04, 8'hB0, 1'b0);
    send(6'h08, 8'h99, 1'b0);
    send(6'h10, 8'h92, 1'b0);
    send(6'h20, 8'h82, 1'b0);
    chk("walk digits", digits, 48'h82_92_99_B0_A4_F9);

    // 13 shifts: old sr[0]=0 ends up on top, so latched = {01,55}
    f = {6'h01, 8'h55};
    expect_frame(1'b0, 1'b1, 6'h01, 8'h55, 1'b0);
    shift_bits({f[12:0], 1'b0}, 13);
    latch();
    send(6'h01, 8'hF9, 1'b0);
    chk("short recover digits", digits, 48'h82_92_99_B0_A4_F9);

    oe = 1'b1;
    clks(4);
    send(6'h04, 8'h3C, 1'b1);
    oe = 1'b0;
    n = 0;
    while (!(seg_q == 8'h3C && sel_q == 6'h04) && n < 3) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk("oe release seg_q", 48'(seg_q), 48'h3C);
    chk("oe release sel_q", 48'(sel_q), 48'h04);

    send(6'b000011, 8'h80, 1'b0);

    shift_bits(14'h2A55, 7);
    sys_rst = 1'b1;
    clks(3);
    sys_rst = 1'b0;
    exp_dig = '0;
    clks(4);
    #1;
    chk("midrst seg_q", 48'(seg_q), 48'h0);
    chk("midrst digits", digits, 48'h0);
    send(6'b100000, 8'h88, 1'b0);
    chk("post rst digits", digits, 48'h88_00_00_00_00_00);

    expect_frame(1'b0, 1'b1, 6'h20, 8'h88, 1'b0);
    latch();

    expect_frame(1'b0, 1'b1, 6'h04, 8'h12, 1'b0);
    for (int i = 0; i < 20; i++) shift_bit(1'b1);
    shift_bits({6'h04, 8'h12}, 14);
    latch();

    f = {6'h08, 8'h7E};
    expect_frame(1'b1, 1'b0, 6'h08, 8'h7E, 1'b0);
    shift_bits(f, 13);
    ds = f[0];
    clks(2);
    shcp = 1'b1;
    stcp = 1'b1;
    clks(4);
    shcp = 1'b0;
    stcp = 1'b0;
    clks(6);
    chk("tied clk digits", digits, 48'h88_00_7E_12_00_00);

    clks(10);
    chk("pending frames", 48'(q.size()), 48'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
